// File: rtl/matmul_pkg.sv
// Shared types and constants for the 2x2 matrix multiplier.
package matmul_pkg;

  localparam int unsigned N      = 2;
  localparam int unsigned ELEM_W = 2;
  localparam int unsigned C_W    = 4;
  localparam int unsigned ACC_W  = 5;
  localparam int unsigned STEPS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  // Bit offset of element (row, col) inside a packed matrix byte; x11 sits at [7:6].
  function automatic logic [2:0] elem_off(input logic row, input logic col);
    return 3'd6 - {row, col, 1'b0};
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate slice: 2b x 2b product into a 5-bit accumulator.
// Define MATMUL_SATURATE_EN to clamp results above 15 instead of wrapping.
module matmul_mac
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              i_step,
  input  logic              i_first,
  input  logic [ELEM_W-1:0] i_a,
  input  logic [ELEM_W-1:0] i_b,
  output logic [C_W-1:0]    o_elem
);

`ifdef MATMUL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [2*ELEM_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_sum;
  logic [ACC_W-1:0]    r_acc;

  assign w_prod = i_a * i_b;
  assign w_sum  = r_acc + ACC_W'(w_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (ena && i_step) begin
      r_acc <= i_first ? ACC_W'(w_prod) : w_sum;
    end
  end

  // Any bit above C_W means the sum exceeds 15.
  assign o_elem = (SAT && (w_sum[ACC_W-1:C_W] != '0)) ? '1 : w_sum[C_W-1:0];

endmodule

// File: rtl/matrix_mult_2x2.sv
// Sequential 2x2 matrix multiplier, one MAC per cycle; results published atomically.
// Build option MATMUL_SATURATE_EN (see matmul_mac) selects clamping over wrapping.
module matrix_mult_2x2 #(
  parameter int unsigned N      = 2,
  parameter int unsigned ELEM_W = 2,
  parameter int unsigned C_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  in_valid,
  input  logic                  in_sel,
  input  logic [N*N*ELEM_W-1:0] in_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [N*C_W-1:0]      c_hi,
  output logic [N*C_W-1:0]      c_lo
);
  import matmul_pkg::*;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_step;
  logic [N*N*ELEM_W-1:0] r_a;
  logic [N*N*ELEM_W-1:0] r_b;
  logic [N*N*C_W-1:0]    r_shadow;
  logic [N*C_W-1:0]      r_c_hi;
  logic [N*C_W-1:0]      r_c_lo;
  logic                  r_done;
  logic                  r_busy;

  logic                  w_i;
  logic                  w_j;
  logic                  w_k;
  logic [ELEM_W-1:0]     w_a;
  logic [ELEM_W-1:0]     w_b;
  logic [C_W-1:0]        w_elem;
  logic                  w_mac;

  // Step s: element e = s>>1 = {i,j}, inner index k = s&1.
  assign w_i   = r_step[2];
  assign w_j   = r_step[1];
  assign w_k   = r_step[0];
  assign w_a   = r_a[elem_off(w_i, w_k) +: ELEM_W];
  assign w_b   = r_b[elem_off(w_k, w_j) +: ELEM_W];
  assign w_mac = (r_state == MAC);

  matmul_mac u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .i_step  (w_mac),
    .i_first (~w_k),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_elem  (w_elem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = MAC;
      MAC:     if (r_step == 3'(STEPS - 1)) w_next = DONE;
      DONE:    if (r_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // DONE spans two cycles: publish + pulse, then drop the pulse on the way out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_shadow <= '0;
      r_c_hi   <= '0;
      r_c_lo   <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else if (ena) begin
      r_busy <= (w_next != IDLE);
      unique case (r_state)
        IDLE: begin
          r_step <= '0;
          if (in_valid) begin
            if (in_sel) r_b <= in_data;
            else        r_a <= in_data;
          end
        end
        MAC: begin
          r_step <= r_step + 3'd1;
          if (w_k) r_shadow[{w_i, w_j, 2'b00} +: C_W] <= w_elem;
        end
        DONE: begin
          if (!r_done) begin
            r_c_hi <= r_shadow[N*C_W-1:0];
            r_c_lo <= r_shadow[N*N*C_W-1:N*C_W];
            r_done <= 1'b1;
          end else begin
            r_done <= 1'b0;
          end
        end
        default: r_step <= '0;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign c_hi = r_c_hi;
  assign c_lo = r_c_lo;

endmodule

// File: tb/tb_matrix_mult_2x2.sv
// Scoreboard bench for matrix_mult_2x2; expected {c_hi,c_lo} queued per run, popped on done.
module tb_matrix_mult_2x2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic       in_sel;
  logic [7:0] in_data;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] c_hi;
  logic [7:0] c_lo;

  logic [15:0] exp_q[$];
  logic [15:0] last_out;
  int          n_tests = 0;
  int          n_fail  = 0;

  matrix_mult_2x2 #(.N(2), .ELEM_W(2), .C_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_valid (in_valid),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .c_hi     (c_hi),
    .c_lo     (c_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product, returned as {c_hi, c_lo}.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    int unsigned s;
    logic [7:0]  ta;
    logic [7:0]  tb;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++) begin
          ta = a >> (6 - 2 * (2 * i + k));
          tb = b >> (6 - 2 * (2 * k + j));
          s += int'(ta & 8'd3) * int'(tb & 8'd3);
        end
`ifdef MATMUL_SATURATE_EN
        if (s > 15) s = 15;
`endif
        r[4 * (2 * i + j) +: 4] = s[3:0];
      end
    end
    return {r[7:0], r[15:8]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input logic [7:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run(input logic [15:0] exp, input int unsigned lat_exp,
                     input bit ldb, input logic [7:0] bdata,
                     input bit disturb, input bit gate);
    int unsigned lat;
    bit          seen;
    exp_q.push_back(exp);
    start = 1'b1;
    if (ldb) begin
      in_valid = 1'b1;
      in_sel   = 1'b1;
      in_data  = bdata;
    end
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("busy_after_start", busy, 1);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      if (disturb && lat == 3) begin
        start    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 8'h00;
      end
      if (gate && lat == 4) ena = 1'b0;
      if (gate && lat == 7) ena = 1'b1;
      if (lat == 5) chk("hold_prev", {c_hi, c_lo}, last_out);
      tick();
      lat++;
      start    = 1'b0;
      in_valid = 1'b0;
      if (done) seen = 1;
    end
    chk("latency", lat, lat_exp);
    tick();
    chk("done_cleared", done, 0);
    chk("busy_cleared", busy, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", done, 0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("c_out", {c_hi, c_lo}, e);
        last_out = e;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    rst_n    = 1'b0;
    ena      = 1'b1;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = 8'h00;
    start    = 1'b0;
    last_out = '0;
    #13;
    chk("rst_c_hi", c_hi, 0);
    chk("rst_c_lo", c_lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // identity
    load(1'b0, 8'h41);
    load(1'b1, 8'h93);
    run(16'h1230, 9, 0, 8'h00, 0, 0);

    // overflow
    load(1'b0, 8'hFF);
    load(1'b1, 8'hFF);
`ifdef MATMUL_SATURATE_EN
    run(16'hFFFF, 9, 0, 8'h00, 0, 0);
`else
    run(16'h2222, 9, 0, 8'h00, 0, 0);
`endif

    // start and load while busy are ignored
    load(1'b0, 8'h41);
    load(1'b1, 8'h93);
    run(16'h1230, 9, 0, 8'h00, 1, 0);
    run(16'h1230, 9, 0, 8'h00, 0, 0);

    // simultaneous load of B with start
    load(1'b1, 8'h00);
    run(16'h1230, 9, 1, 8'h93, 0, 0);

    // reset mid-run
    load(1'b0, 8'h41);
    load(1'b1, 8'h93);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_c_hi", c_hi, 0);
    chk("midrst_c_lo", c_lo, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    last_out = '0;
    #2;
    rst_n = 1'b1;
    tick();
    load(1'b0, 8'h41);
    load(1'b1, 8'h93);
    run(16'h1230, 9, 0, 8'h00, 0, 0);

    // clock-enable freeze for 3 cycles
    run(16'h1230, 12, 0, 8'h00, 0, 1);

    // random operands
    for (int n = 0; n < 4; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      load(1'b0, ra);
      load(1'b1, rb);
      run(model(ra, rb), 9, 0, 8'h00, 0, 0);
    end

    tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
